// File: rtl/calc_controller_param.sv
// Serial-key unlocked controller: loads a mode after unlock, queues read/write commands
// and sequences memory access, data sampling and a timeout-bounded TX handshake.
module calc_controller_param #(
    parameter int                 KEY_LEN    = 8,
    parameter logic [KEY_LEN-1:0] KEY_VALUE  = KEY_LEN'(8'hA5),
    parameter int                 MODE_W     = 2,
    parameter int                 CMD_DEPTH  = 4,
    parameter int                 TX_TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InputKey,
    input  logic              ValidCmd,
    input  logic              RW,
    input  logic              TxDone,
    output logic              Active,
    output logic [MODE_W-1:0] Mode,
    output logic              AccessMem,
    output logic              RWMem,
    output logic              SampleData,
    output logic              TxData,
    output logic              Busy,
    output logic              CmdDrop,
    output logic              Timeout
);
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TX_TIMEOUT + 1);
    localparam int BIT_W = $clog2(MODE_W + 1);

    typedef enum logic [1:0] {K_LOCK, K_MODE_LOAD, K_ACTIVE} key_state_t;
    typedef enum logic [2:0] {F_IDLE, F_WR_SMP, F_WR_ACC, F_RD_ACC, F_TX} flow_state_t;

    key_state_t         key_state, key_next;
    logic [KEY_LEN-1:0] shreg, shreg_d, shreg_shift;
    logic [MODE_W-1:0]  mode_d;
    logic [BIT_W-1:0]   bitcnt, bitcnt_d;
    logic               lock_pending, lock_pending_d;
    logic               sample, key_match;

    flow_state_t        flow_state, flow_next;
    logic [TMR_W-1:0]   timer, timer_d;
    logic               timeout_d;

    logic               cmd_mem [CMD_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_d;
    logic               full, pop, push_req, push_ok, drop;

    // Key bits are only taken on cycles without a command strobe.
    assign sample      = ~ValidCmd;
    assign shreg_shift = (shreg << 1) | KEY_LEN'(InputKey);
    assign key_match   = sample && (shreg_shift == KEY_VALUE);

    always_comb begin
        key_next       = key_state;
        shreg_d        = shreg;
        mode_d         = Mode;
        bitcnt_d       = bitcnt;
        lock_pending_d = lock_pending;
        if (sample)
            shreg_d = shreg_shift;
        case (key_state)
            K_LOCK: begin
                if (key_match) begin
                    key_next = K_MODE_LOAD;
                    bitcnt_d = '0;
                end
            end
            K_MODE_LOAD: begin
                if (sample) begin
                    mode_d   = (Mode << 1) | MODE_W'(InputKey);
                    bitcnt_d = bitcnt + 1'b1;
                    if (bitcnt == BIT_W'(MODE_W - 1)) begin
                        key_next = K_ACTIVE;
                        shreg_d  = '0;
                    end
                end
            end
            K_ACTIVE: begin
                // Relock waits until every queued command has been carried out.
                if (lock_pending && !Busy && sample) begin
                    key_next       = K_LOCK;
                    mode_d         = '0;
                    lock_pending_d = 1'b0;
                end else if (key_match) begin
                    lock_pending_d = 1'b1;
                end
            end
            default: key_next = K_LOCK;
        endcase
    end

    assign push_req = ValidCmd & Active;
    assign full     = (count == CNT_W'(CMD_DEPTH));
    assign pop      = (flow_state == F_IDLE) && (count != '0);
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign count_d  = count + CNT_W'(push_ok) - CNT_W'(pop);

    always_comb begin
        flow_next = flow_state;
        timer_d   = timer;
        timeout_d = 1'b0;
        case (flow_state)
            F_IDLE: begin
                if (pop)
                    flow_next = cmd_mem[rd_ptr] ? F_WR_SMP : F_RD_ACC;
            end
            F_WR_SMP: flow_next = F_WR_ACC;
            F_WR_ACC: flow_next = F_IDLE;
            F_RD_ACC: begin
                flow_next = F_TX;
                timer_d   = '0;
            end
            F_TX: begin
                if (TxDone) begin
                    flow_next = F_IDLE;
                end else if (timer == TMR_W'(TX_TIMEOUT - 1)) begin
                    flow_next = F_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            default: flow_next = F_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            key_state    <= K_LOCK;
            shreg        <= '0;
            Mode         <= '0;
            bitcnt       <= '0;
            lock_pending <= 1'b0;
            Active       <= 1'b0;
            flow_state   <= F_IDLE;
            timer        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            AccessMem    <= 1'b0;
            RWMem        <= 1'b0;
            SampleData   <= 1'b0;
            TxData       <= 1'b0;
            Busy         <= 1'b0;
            CmdDrop      <= 1'b0;
            Timeout      <= 1'b0;
        end else begin
            key_state    <= key_next;
            shreg        <= shreg_d;
            Mode         <= mode_d;
            bitcnt       <= bitcnt_d;
            lock_pending <= lock_pending_d;
            Active       <= (key_next == K_ACTIVE);
            flow_state   <= flow_next;
            timer        <= timer_d;
            count        <= count_d;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            AccessMem    <= (flow_next == F_WR_ACC) || (flow_next == F_RD_ACC);
            RWMem        <= (flow_next == F_WR_ACC);
            SampleData   <= (flow_next == F_WR_SMP);
            TxData       <= (flow_next == F_TX);
            Busy         <= (flow_next != F_IDLE) || (count_d != '0);
            CmdDrop      <= drop;
            Timeout      <= timeout_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push_ok)
            cmd_mem[wr_ptr] <= RW;
    end

endmodule

// File: tb/tb_calc_controller_param.sv
// Bench for calc_controller_param: queue-based reference model compared every cycle,
// plus directed scenarios with hand-derived expectations.
module tb_calc_controller_param;
    localparam int KL    = 8;
    localparam int KEYV  = 'hA5;
    localparam int MW    = 2;
    localparam int DEPTH = 4;
    localparam int TO    = 255;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          InputKey, ValidCmd, RW, TxDone;
    logic          Active, AccessMem, RWMem, SampleData, TxData, Busy, CmdDrop, Timeout;
    logic [MW-1:0] Mode;

    int passed = 0;
    int total  = 0;
    int n_acc, n_drop, n_tx, n_tout;

    calc_controller_param #(
        .KEY_LEN(KL), .KEY_VALUE(8'hA5), .MODE_W(MW), .CMD_DEPTH(DEPTH), .TX_TIMEOUT(TO)
    ) dut (
        .Clk(Clk), .Reset(Reset), .InputKey(InputKey), .ValidCmd(ValidCmd), .RW(RW),
        .TxDone(TxDone), .Active(Active), .Mode(Mode), .AccessMem(AccessMem), .RWMem(RWMem),
        .SampleData(SampleData), .TxData(TxData), .Busy(Busy), .CmdDrop(CmdDrop),
        .Timeout(Timeout)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: key phase, command queue and the job currently being executed.
    int            m_phase = 0;   // 0 locked, 1 loading mode, 2 active
    int            m_hist = 0, m_nbits = 0, m_job = 0, m_held = 0;
    bit            m_lp = 0;
    bit            q[$];
    logic [MW-1:0] m_mode = '0;
    logic          m_active = 0, m_acc = 0, m_rwmem = 0, m_smp = 0, m_tx = 0;
    logic          m_busy = 0, m_drop = 0, m_tout = 0;

    always @(posedge Clk or negedge Reset) begin
        bit samp, was_full, popped, old_busy, old_active;
        if (!Reset) begin
            m_phase = 0; m_hist = 0; m_nbits = 0; m_job = 0; m_held = 0; m_lp = 0;
            m_mode = '0; q.delete();
            {m_active, m_acc, m_rwmem, m_smp, m_tx, m_busy, m_drop, m_tout} = '0;
        end else begin
            samp       = !ValidCmd;
            old_busy   = m_busy;
            old_active = m_active;
            {m_acc, m_rwmem, m_smp, m_tx, m_drop, m_tout} = '0;
            was_full = (q.size() == DEPTH);
            popped   = (m_job == 0) && (q.size() != 0);
            // job: 0 none, 1 sample, 2 write access, 3 read access, 4 waiting on TX
            case (m_job)
                0: if (popped) begin
                    if (q.pop_front()) begin m_job = 1; m_smp = 1; end
                    else begin m_job = 3; m_acc = 1; end
                end
                1: begin m_job = 2; m_acc = 1; m_rwmem = 1; end
                2: m_job = 0;
                3: begin m_job = 4; m_held = 1; m_tx = 1; end
                default: begin
                    if (TxDone) m_job = 0;
                    else if (m_held == TO) begin m_job = 0; m_tout = 1; end
                    else begin m_held++; m_tx = 1; end
                end
            endcase
            if (ValidCmd && old_active) begin
                if (was_full && !popped) m_drop = 1;
                else q.push_back(RW);
            end
            m_busy = (m_job != 0) || (q.size() != 0);
            if (samp) m_hist = ((m_hist << 1) | int'(InputKey)) & ((1 << KL) - 1);
            case (m_phase)
                0: if (samp && m_hist == KEYV) begin m_phase = 1; m_nbits = 0; end
                1: if (samp) begin
                    m_mode = (m_mode << 1) | MW'(InputKey);
                    m_nbits++;
                    if (m_nbits == MW) begin m_phase = 2; m_hist = 0; end
                end
                default: begin
                    if (m_lp && !old_busy && samp) begin m_phase = 0; m_mode = '0; m_lp = 0; end
                    else if (samp && m_hist == KEYV) m_lp = 1;
                end
            endcase
            m_active = (m_phase == 2);
        end
    end

    always @(negedge Clk) begin
        check("outputs_vs_model",
              {22'b0, Active, Mode, AccessMem, RWMem, SampleData, TxData, Busy, CmdDrop, Timeout},
              {22'b0, m_active, m_mode, m_acc, m_rwmem, m_smp, m_tx, m_busy, m_drop, m_tout});
    end

    task automatic step(input logic k, input logic v, input logic r, input logic t);
        InputKey = k; ValidCmd = v; RW = r; TxDone = t;
        @(negedge Clk);
        n_acc  += int'(AccessMem);
        n_drop += int'(CmdDrop);
        n_tx   += int'(TxData);
        n_tout += int'(Timeout);
    endtask

    task automatic send_bits(input logic [7:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) step(val[i], 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clr();
        n_acc = 0; n_drop = 0; n_tx = 0; n_tout = 0;
    endtask

    initial begin
        Reset = 1'b0; InputKey = 1'b0; ValidCmd = 1'b0; RW = 1'b0; TxDone = 1'b0;
        clr();
        repeat (2) @(negedge Clk);
        check("reset_active", Active, 0);
        check("reset_mode", Mode, 0);
        check("reset_busy", Busy, 0);
        check("reset_txdata", TxData, 0);
        Reset = 1'b1;

        // Wrong key, then the right one followed by mode bits 1,0
        send_bits(8'hA4, 8);
        check("wrong_key_active", Active, 0);
        send_bits(8'hA5, 8);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("mid_mode_active", Active, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("unlock_active", Active, 1);
        check("unlock_mode", Mode, 2'b10);

        // Write command; a stray TxDone while idle has no effect
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("wr_busy", Busy, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("wr_sample", SampleData, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("wr_access", {SampleData, AccessMem, RWMem}, 3'b011);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("wr_done", {AccessMem, Busy}, 2'b00);

        // Read with TxDone in the third TX cycle
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rd_access", {AccessMem, RWMem}, 2'b10);
        clr();
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rd_tx_cycles", n_tx, 3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("rd_tx_released", {TxData, Busy}, 2'b00);

        // Read with no TxDone at all: abandoned after TO cycles
        clr();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 400 && n_tout == 0; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("timeout_tx_cycles", n_tx, TO);
        check("timeout_pulses", n_tout, 1);

        // Six back-to-back reads with TX stalled, then drain
        clr();
        repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("burst_drop_now", CmdDrop, 1);
        for (int i = 0; i < 100 && Busy; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("burst_drops", n_drop, 1);
        check("burst_accesses", n_acc, 5);
        check("burst_idle", Busy, 0);

        // Relock key while two reads wait behind a stalled one
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(8'hA5, 8);
        check("relock_pending_active", Active, 1);
        clr();
        for (int i = 0; i < 100 && Active; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("relock_drained_accesses", n_acc, 2);
        check("relock_active", Active, 0);
        check("relock_mode", Mode, 0);

        // Unlock with mode 0,1 then reset asynchronously during TX
        repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(8'hA5, 8);
        send_bits(8'h01, 2);
        check("reunlock_mode", {Active, Mode}, 3'b101);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10 && !TxData; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_reset_txdata", TxData, 1);
        #2 Reset = 1'b0;
        #1;
        check("async_reset_outputs", {Active, Mode, AccessMem, TxData, Busy}, 6'b0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("post_reset_idle", {Active, Busy, TxData}, 3'b000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
